pipeline_hazard_ctrl: RTL and testbench

Decode-stage sequencer for the 5-stage RV32I pipeline. It tracks in-flight destination registers and stalls or bubbles decode on data hazards. It flushes wrong-path instructions when execute resolves a taken branch or jump. It drives fetch/decode stall and flush strobes and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the decode hazard controller: instruction classes, FSM states, scoreboard entry.
package HazardCtrlPkg;

    typedef enum logic [3:0] {
        ALU_REG = 4'd0,
        ALU_IMM = 4'd1,
        LOAD    = 4'd2,
        STORE   = 4'd3,
        BRANCH  = 4'd4,
        JUMP    = 4'd5,
        LUI     = 4'd6,
        AUIPC   = 4'd7,
        SYSTEM  = 4'd8
    } InstructionTypes;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } HazardState_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       isLoad;
    } SbEntry_t;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Two-entry EX/MEM destination tracker with same-cycle source-match flags.
// Entries shift every cycle; no backpressure, the producer side pushes a bubble when not issuing.
module hazard_scoreboard
    import HazardCtrlPkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_vld,
    input  logic [4:0] push_rd,
    input  logic       push_load,
    input  logic [4:0] rs1,
    input  logic       use_rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs2,
    output logic       match_ex,
    output logic       match_ex_load,
    output logic       match_mem
);

    SbEntry_t ex_q;
    SbEntry_t mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q        <= ex_q;
            ex_q.valid   <= push_vld && (push_rd != 5'd0);
            ex_q.rd      <= push_rd;
            ex_q.isLoad  <= push_load;
        end
    end

    function automatic logic hit(input SbEntry_t e, input logic [4:0] a, input logic ua,
                                 input logic [4:0] b, input logic ub);
        return e.valid && ((ua && (a == e.rd)) || (ub && (b == e.rd)));
    endfunction

    always_comb begin
        match_ex      = hit(ex_q, rs1, use_rs1, rs2, use_rs2);
        match_ex_load = match_ex && ex_q.isLoad;
        match_mem     = hit(mem_q, rs1, use_rs1, rs2, use_rs2);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode hazard/flush sequencer; strobes are same-cycle combinational, state updates next edge.
// FORWARDING_EN selects load-use-only stalls (bypass build) versus EX+MEM dependency stalls.
module pipeline_hazard_ctrl
    import HazardCtrlPkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iDecValid,
    input  InstructionTypes  iDecType,
    input  logic [4:0]       iDecRs1,
    input  logic [4:0]       iDecRs2,
    input  logic             iDecUsesRs1,
    input  logic             iDecUsesRs2,
    input  logic [4:0]       iDecRd,
    input  logic             iDecRegWrite,
    input  logic             iExRedirect,
    output logic             oStallF,
    output logic             oStallD,
    output logic             oFlushD,
    output logic             oFlushE,
    output logic             oIssue,
    output logic [1:0]       oState,
    output logic [CNT_W-1:0] oStallCycles,
    output logic [CNT_W-1:0] oFlushCycles
);

    HazardState_t           state_q, state_nxt;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0]       stall_cnt_q, flush_cnt_q;
    logic                   match_ex, match_ex_load, match_mem;
    logic                   hazard;
    logic                   stall, flush_d, flush_e, issue;

    hazard_scoreboard u_sb (
        .clk           (iClk),
        .rst           (iRst),
        .push_vld      (issue && iDecRegWrite),
        .push_rd       (iDecRd),
        .push_load     (iDecType == LOAD),
        .rs1           (iDecRs1),
        .use_rs1       (iDecUsesRs1),
        .rs2           (iDecRs2),
        .use_rs2       (iDecUsesRs2),
        .match_ex      (match_ex),
        .match_ex_load (match_ex_load),
        .match_mem     (match_mem)
    );

`ifdef FORWARDING_EN
    assign hazard = iDecValid && match_ex_load;
`else
    assign hazard = iDecValid && (match_ex || match_ex_load || match_mem);
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_d && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // Priority: redirect, then FLUSH countdown, then hazard, then issue.
    always_comb begin
        state_nxt = RUN;
        cnt_nxt   = cnt_q;
        stall     = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        issue     = 1'b0;
        if (iExRedirect) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            cnt_nxt   = FLUSH_CNT_W'(FLUSH_CYCLES);
            state_nxt = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        end else if (state_q == FLUSH) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (cnt_q <= FLUSH_CNT_W'(1)) begin
                cnt_nxt   = '0;
                state_nxt = hazard ? STALL : RUN;
            end else begin
                cnt_nxt   = cnt_q - FLUSH_CNT_W'(1);
                state_nxt = FLUSH;
            end
        end else if (hazard) begin
            stall     = 1'b1;
            flush_e   = 1'b1;
            state_nxt = STALL;
        end else begin
            issue     = iDecValid;
            state_nxt = RUN;
        end
    end

    // Reset forces every output low, including the not-yet-cleared counters.
    assign oStallF      = !iRst && stall;
    assign oStallD      = !iRst && stall;
    assign oFlushD      = !iRst && flush_d;
    assign oFlushE      = !iRst && flush_e;
    assign oIssue       = !iRst && issue;
    assign oState       = iRst ? 2'd0 : state_q;
    assign oStallCycles = iRst ? '0 : stall_cnt_q;
    assign oFlushCycles = iRst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-history reference model.
module tb_pipeline_hazard_ctrl;
    import HazardCtrlPkg::*;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic            iClk = 1'b0;
    logic            iRst;
    logic            iDecValid;
    InstructionTypes iDecType;
    logic [4:0]      iDecRs1, iDecRs2, iDecRd;
    logic            iDecUsesRs1, iDecUsesRs2, iDecRegWrite, iExRedirect;
    logic            oStallF, oStallD, oFlushD, oFlushE, oIssue;
    logic [1:0]      oState;
    logic [CW-1:0]   oStallCycles, oFlushCycles;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .iClk(iClk), .iRst(iRst), .iDecValid(iDecValid), .iDecType(iDecType),
        .iDecRs1(iDecRs1), .iDecRs2(iDecRs2), .iDecUsesRs1(iDecUsesRs1),
        .iDecUsesRs2(iDecUsesRs2), .iDecRd(iDecRd), .iDecRegWrite(iDecRegWrite),
        .iExRedirect(iExRedirect), .oStallF(oStallF), .oStallD(oStallD),
        .oFlushD(oFlushD), .oFlushE(oFlushE), .oIssue(oIssue), .oState(oState),
        .oStallCycles(oStallCycles), .oFlushCycles(oFlushCycles)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: log of what issued in previous cycles, newest first.
    typedef struct {
        bit       wr;
        bit [4:0] rd;
        bit       load;
    } issue_rec_t;

    issue_rec_t log_q[$];
    int since_redir = 100;
    bit prev_hz = 0, prev_redir = 0;
    int stall_n = 0, flush_n = 0;
    bit m_issue, m_stall, m_fd, m_fe, m_hz;

    function automatic bit dep(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        for (int d = 1; d <= 2; d++) begin
            if (d <= log_q.size() && log_q[d-1].wr && log_q[d-1].rd == r) begin
`ifdef FORWARDING_EN
                if (d == 1 && log_q[d-1].load) return 1'b1;
`else
                return 1'b1;
`endif
            end
        end
        return 1'b0;
    endfunction

    task automatic model_check();
        int  exp_state;
        bit  in_win;
        m_hz    = iDecValid && ((iDecUsesRs1 && dep(iDecRs1)) || (iDecUsesRs2 && dep(iDecRs2)));
        in_win  = (since_redir >= 1) && (since_redir <= FC);
        m_issue = 0; m_stall = 0; m_fd = 0; m_fe = 0;
        if (iExRedirect) begin
            m_fd = 1; m_fe = 1;
        end else if (in_win) begin
            m_fd = 1; m_fe = 1;
        end else if (m_hz) begin
            m_stall = 1; m_fe = 1;
        end else begin
            m_issue = iDecValid;
        end
        exp_state = in_win ? 2 : (prev_redir ? 0 : (prev_hz ? 1 : 0));
        if (iRst) begin
            m_issue = 0; m_stall = 0; m_fd = 0; m_fe = 0;
        end
        check_eq("stallF", oStallF, m_stall);
        check_eq("stallD", oStallD, m_stall);
        check_eq("flushD", oFlushD, m_fd);
        check_eq("flushE", oFlushE, m_fe);
        check_eq("issue",  oIssue,  m_issue);
        check_eq("state",  oState,  iRst ? 0 : exp_state);
        check_eq("stall_cnt", oStallCycles, iRst ? 0 : stall_n);
        check_eq("flush_cnt", oFlushCycles, iRst ? 0 : flush_n);
    endtask

    task automatic model_commit();
        issue_rec_t e;
        if (iRst) begin
            log_q.delete();
            since_redir = 100; prev_hz = 0; prev_redir = 0;
            stall_n = 0; flush_n = 0;
            return;
        end
        e.wr = m_issue && iDecRegWrite;
        e.rd = iDecRd;
        e.load = (iDecType == LOAD);
        log_q.push_front(e);
        if (log_q.size() > 2) void'(log_q.pop_back());
        if (m_stall && stall_n < MAXC) stall_n++;
        if (m_fd && flush_n < MAXC) flush_n++;
        since_redir = iExRedirect ? 1 : ((since_redir < 100) ? since_redir + 1 : 100);
        prev_redir = iExRedirect;
        prev_hz    = m_hz;
    endtask

    task automatic step();
        @(negedge iClk);
        model_check();
        @(posedge iClk);
        model_commit();
        #1;
    endtask

    task automatic set_in(input bit v, input InstructionTypes t, input int rs1, input bit u1,
                          input int rs2, input bit u2, input int rd, input bit w, input bit rdr);
        iDecValid = v; iDecType = t;
        iDecRs1 = 5'(rs1); iDecUsesRs1 = u1;
        iDecRs2 = 5'(rs2); iDecUsesRs2 = u2;
        iDecRd = 5'(rd); iDecRegWrite = w; iExRedirect = rdr;
    endtask

    task automatic idle();
        set_in(0, ALU_REG, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        iRst = 1'b1;
        set_in(1, LOAD, 1, 1, 2, 1, 1, 1, 1);
        step();
        step();
        check_eq("rst_state", oState, 0);
        iRst = 1'b0;
        idle();
        #1;
        check_eq("rst_cnt", oStallCycles, 0);
        step();

`ifdef FORWARDING_EN
        set_in(1, LOAD, 0, 0, 0, 0, 5, 1, 0);
        step();
        set_in(1, ALU_IMM, 5, 1, 0, 0, 6, 1, 0);
        #1; check_eq("lu_stall", oStallD, 1);
        step();
        #1; check_eq("lu_issue", oIssue, 1);
        step();
        idle();
        step();
        check_eq("lu_cnt", oStallCycles, 1);
`else
        set_in(1, ALU_REG, 1, 1, 2, 1, 3, 1, 0);
        step();
        set_in(1, ALU_REG, 4, 1, 3, 1, 7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1; check_eq("dep_issue", oIssue, (i == 2) ? 1 : 0);
            step();
        end
        idle();
        step();
        check_eq("dep_cnt", oStallCycles, 2);
`endif

        do_reset();
        set_in(1, LOAD, 1, 1, 0, 0, 0, 1, 0);
        step();
        set_in(1, ALU_IMM, 0, 1, 0, 0, 6, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1; check_eq("x0_issue", oIssue, 1);
            step();
        end
        idle();
        step();
        check_eq("x0_cnt", oStallCycles, 0);

        do_reset();
        set_in(0, ALU_REG, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            check_eq("rd_state", oState, (i < 2) ? 2 : 0);
            step();
        end
        check_eq("rd_fcnt", oFlushCycles, 3);

        do_reset();
        set_in(1, LOAD, 0, 0, 0, 0, 4, 1, 0);
        step();
        set_in(1, ALU_REG, 4, 1, 4, 1, 8, 1, 1);
        #1;
        check_eq("rdh_stall", oStallD, 0);
        check_eq("rdh_flush", oFlushD, 1);
        check_eq("rdh_issue", oIssue, 0);
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        check_eq("rdh_scnt", oStallCycles, 0);

        do_reset();
        set_in(0, ALU_REG, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        step();
        iRst = 1'b1;
        #1;
        check_eq("rmf_flush", oFlushD, 0);
        check_eq("rmf_state", oState, 0);
        step();
        iRst = 1'b0;
        #1;
        check_eq("rmf_state2", oState, 0);
        check_eq("rmf_flush2", oFlushD, 0);
        check_eq("rmf_fcnt", oFlushCycles, 0);
        step();

        for (int n = 0; n < 3000; n++) begin
            iRst         = ($urandom_range(0, 149) == 0);
            iDecValid    = ($urandom_range(0, 7) != 0);
            iDecType     = ($urandom_range(0, 2) == 0) ? LOAD : InstructionTypes'(4'($urandom_range(0, 8)));
            iDecRs1      = 5'($urandom_range(0, 3));
            iDecRs2      = 5'($urandom_range(0, 3));
            iDecUsesRs1  = ($urandom_range(0, 3) != 0);
            iDecUsesRs2  = ($urandom_range(0, 1) != 0);
            iDecRd       = 5'($urandom_range(0, 3));
            iDecRegWrite = ($urandom_range(0, 4) != 0);
            iExRedirect  = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
